// File: rtl/axi4_sram_ctrl_if.sv
// AXI4 bus bundle shared by the SRAM controller and its masters.
// Only the signals the controller uses are carried.
`timescale 1ns/1ps
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic [USER_WIDTH-1:0]   buser;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [USER_WIDTH-1:0]   ruser;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_sram_ctrl.sv
// AXI4 slave in front of a single-port SRAM with 1-cycle read latency.
// One burst at a time; write/read arbitration alternates on ties.
`timescale 1ns/1ps
module axi4_sram_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int ID_WIDTH       = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  axi4_if.slave                     axi_if,
  output logic                      o_mem_en,
  output logic                      o_mem_we,
  output logic [MEM_DEPTH_LOG2-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   o_mem_wstrb,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);
  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(STRB_W);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WDATA = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] RADDR = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  logic [2:0]            state;
  logic                  last_wr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [8:0]            beat_cnt;
  logic [8:0]            beat_inc;
  logic                  beat_is_last;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [1:0]            bresp_q;
  logic                  rd_first;
  logic [DATA_WIDTH-1:0] rdata_p1;
  logic                  grant_wr;
  logic                  grant_rd;
  logic                  wr_hs;

  // Reserved burst encoding behaves as INCR.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    step = ADDR_WIDTH'(1) << size;
    mask = (ADDR_WIDTH'({1'b0, len} + 9'd1) << size) - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: next_addr = a;
      BURST_WRAP:  next_addr = (a & ~mask) | ((a + step) & mask);
      default:     next_addr = a + step;
    endcase
  endfunction

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (i_rst_n && state == IDLE) begin
      if (axi_if.awvalid && (!axi_if.arvalid || !last_wr)) grant_wr = 1'b1;
      else if (axi_if.arvalid)                             grant_rd = 1'b1;
    end
  end

  assign addr_nxt     = next_addr(addr_q, len_q, size_q, burst_q);
  assign beat_inc     = (&beat_cnt) ? beat_cnt : beat_cnt + 9'd1;
  assign beat_is_last = (beat_cnt == {1'b0, len_q});
  assign wr_hs        = (state == WDATA) && axi_if.wvalid;

  assign axi_if.awready = grant_wr;
  assign axi_if.arready = grant_rd;
  assign axi_if.wready  = (state == WDATA);
  assign axi_if.bvalid  = (state == WRESP);
  assign axi_if.bresp   = bresp_q;
  assign axi_if.bid     = bid_q;
  assign axi_if.buser   = '0;
  assign axi_if.rvalid  = (state == RDATA);
  assign axi_if.rlast   = (state == RDATA) && beat_is_last;
  assign axi_if.rresp   = RESP_OKAY;
  assign axi_if.rid     = rid_q;
  assign axi_if.ruser   = '0;

  // SRAM data is live only in the first RDATA cycle; afterwards the captured copy is held.
  assign axi_if.rdata = (state != RDATA) ? '0 :
                        rd_first         ? i_mem_rdata : rdata_p1;

  assign o_mem_en    = wr_hs || (state == RADDR);
  assign o_mem_we    = wr_hs;
  assign o_mem_addr  = MEM_DEPTH_LOG2'(addr_q >> BYTE_SHIFT);
  assign o_mem_wdata = wr_hs ? axi_if.wdata : '0;
  assign o_mem_wstrb = wr_hs ? axi_if.wstrb : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      last_wr  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_cnt <= '0;
      bid_q    <= '0;
      rid_q    <= '0;
      bresp_q  <= RESP_OKAY;
      rd_first <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            addr_q   <= axi_if.awaddr;
            len_q    <= axi_if.awlen;
            size_q   <= axi_if.awsize;
            burst_q  <= axi_if.awburst;
            bid_q    <= axi_if.awid;
            beat_cnt <= '0;
            last_wr  <= 1'b1;
            state    <= WDATA;
          end else if (grant_rd) begin
            addr_q   <= axi_if.araddr;
            len_q    <= axi_if.arlen;
            size_q   <= axi_if.arsize;
            burst_q  <= axi_if.arburst;
            rid_q    <= axi_if.arid;
            beat_cnt <= '0;
            last_wr  <= 1'b0;
            state    <= RADDR;
          end
        end
        WDATA: begin
          if (axi_if.wvalid) begin
            addr_q   <= addr_nxt;
            beat_cnt <= beat_inc;
            if (axi_if.wlast) begin
              bresp_q <= beat_is_last ? RESP_OKAY : RESP_SLVERR;
              state   <= WRESP;
            end
          end
        end
        WRESP: begin
          if (axi_if.bready) state <= IDLE;
        end
        RADDR: begin
          rd_first <= 1'b1;
          state    <= RDATA;
        end
        RDATA: begin
          rd_first <= 1'b0;
          if (rd_first) rdata_p1 <= i_mem_rdata;
          if (axi_if.rready) begin
            addr_q   <= addr_nxt;
            beat_cnt <= beat_inc;
            state    <= beat_is_last ? IDLE : RADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_sram_ctrl.sv
// Bench for axi4_sram_ctrl: table of bursts plus hand-written tie and reset sequences.
`timescale 1ns/1ps
module tb_axi4_sram_ctrl;
  logic        i_clk;
  logic        i_rst_n;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [9:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] i_mem_rdata;

  axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

  axi4_sram_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH_LOG2(10), .ID_WIDTH(4)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .axi_if(bus),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb), .i_mem_rdata(i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // SRAM model: registered read port, byte-enabled write
  logic [31:0] mem [0:1023];
  always @(posedge i_clk) begin
    if (o_mem_en) begin
      if (o_mem_we) begin
        for (int b = 0; b < 4; b++)
          if (o_mem_wstrb[b]) mem[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      end else begin
        i_mem_rdata <= mem[o_mem_addr];
      end
    end
  end

  int overlap_cnt = 0;
  always @(negedge i_clk) begin
    #2;
    if (bus.awready && bus.arready) overlap_cnt <= overlap_cnt + 1;
  end

  typedef struct packed {
    bit             wr;
    logic [31:0]    addr;
    logic [7:0]     len;
    logic [2:0]     size;
    logic [1:0]     burst;
    logic [3:0]     id;
    logic [3:0]     nbeats;
    logic [3:0][9:0] exp_w;
    logic [1:0]     exp_resp;
    logic [31:0]    data0;
    logic [3:0]     last_strb;
  } txn_t;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wexp_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  wexp_t       wr_q[$];
  rexp_t       rd_q[$];
  logic [31:0] shadow [0:1023];
  int          n_checks = 0;
  int          n_pass   = 0;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return bus.awready;
      1:       return bus.arready;
      2:       return bus.wready;
      3:       return bus.bvalid;
      4:       return bus.rvalid;
      default: return 1'b0;
    endcase
  endfunction

  // Called at a falling edge; returns 1 cycle-settled after the signal is seen high.
  task automatic wait_hi(input int s, input string name, output bit ok);
    int n;
    n = 0;
    #1;
    while (!sig(s) && n < 50) begin
      @(negedge i_clk); #1; n++;
    end
    ok = sig(s);
    if (!ok) begin
      n_checks++;
      $display("FAIL timeout_%s: got 0, expected 1 within 50 cycles", name);
    end
  endtask

  function automatic txn_t mk(input bit wr, input logic [31:0] addr, input int len, input int size,
                              input logic [1:0] burst, input int id, input int nb,
                              input int w0, input int w1, input int w2, input int w3,
                              input logic [1:0] resp, input logic [31:0] d0, input logic [3:0] ls);
    txn_t t;
    t.wr = wr; t.addr = addr; t.len = 8'(len); t.size = 3'(size); t.burst = burst;
    t.id = 4'(id); t.nbeats = 4'(nb);
    t.exp_w[0] = 10'(w0); t.exp_w[1] = 10'(w1); t.exp_w[2] = 10'(w2); t.exp_w[3] = 10'(w3);
    t.exp_resp = resp; t.data0 = d0; t.last_strb = ls;
    return t;
  endfunction

  task automatic set_aw(input txn_t t);
    bus.awid = t.id; bus.awaddr = t.addr; bus.awlen = t.len;
    bus.awsize = t.size; bus.awburst = t.burst; bus.awvalid = 1'b1;
  endtask

  task automatic set_ar(input txn_t t);
    bus.arid = t.id; bus.araddr = t.addr; bus.arlen = t.len;
    bus.arsize = t.size; bus.arburst = t.burst; bus.arvalid = 1'b1;
  endtask

  task automatic aw_handshake();
    bit ok;
    wait_hi(0, "awready", ok);
    @(negedge i_clk); bus.awvalid = 1'b0;
  endtask

  task automatic ar_handshake(input txn_t t);
    bit ok;
    wait_hi(1, "arready", ok);
    for (int i = 0; i <= int'(t.len); i++)
      rd_q.push_back({shadow[t.exp_w[i]], (i == int'(t.len)), t.id});
    @(negedge i_clk); bus.arvalid = 1'b0;
  endtask

  task automatic w_phase(input txn_t t);
    bit ok;
    int prev;
    logic [31:0] d;
    logic [3:0]  s;
    wexp_t e;
    prev = 0;
    for (int i = 0; i < int'(t.nbeats); i++) begin
      d = t.data0 + 32'(i);
      s = (i == int'(t.nbeats) - 1) ? t.last_strb : 4'hF;
      bus.wdata = d; bus.wstrb = s; bus.wlast = (i == int'(t.nbeats) - 1); bus.wvalid = 1'b1;
      wr_q.push_back({t.exp_w[i], d, s});
      for (int b = 0; b < 4; b++) if (s[b]) shadow[t.exp_w[i]][8*b +: 8] = d[8*b +: 8];
      wait_hi(2, "wready", ok);
      chk("sram_write_strobe", {o_mem_en, o_mem_we}, 2'b11);
      if (o_mem_en && o_mem_we && wr_q.size() > 0) begin
        e = wr_q.pop_front();
        chk("sram_write_addr", o_mem_addr, e.addr);
        chk("sram_write_data", o_mem_wdata, e.data);
        chk("sram_write_strb", o_mem_wstrb, e.strb);
      end
      if (i > 0) chk("write_beat_spacing", cyc - prev, 1);
      prev = cyc;
      @(negedge i_clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic b_phase(input txn_t t);
    bit ok;
    bus.bready = 1'b1;
    wait_hi(3, "bvalid", ok);
    chk("bresp", bus.bresp, t.exp_resp);
    chk("bid", bus.bid, t.id);
    @(negedge i_clk); bus.bready = 1'b0;
    chk("write_scoreboard_drained", wr_q.size(), 0);
  endtask

  task automatic r_phase(input txn_t t);
    bit ok;
    int prev;
    rexp_t e;
    prev = 0;
    bus.rready = 1'b1;
    for (int i = 0; i <= int'(t.len); i++) begin
      wait_hi(4, "rvalid", ok);
      if (!ok) break;
      if (rd_q.size() == 0) begin
        n_checks++;
        $display("FAIL read_unexpected_beat: got beat %0d, expected none", i);
      end else begin
        e = rd_q.pop_front();
        chk("rdata", bus.rdata, e.data);
        chk("rlast", bus.rlast, e.last);
        chk("rid", bus.rid, e.id);
        chk("rresp", bus.rresp, 2'b00);
      end
      if (i > 0) chk("read_beat_spacing", cyc - prev, 2);
      prev = cyc;
      @(negedge i_clk);
    end
    bus.rready = 1'b0;
  endtask

  task automatic tie_round(input txn_t tw, input txn_t tr);
    @(negedge i_clk);
    set_aw(tw); set_ar(tr);
    #1;
    chk("tie_awready", bus.awready, 1'b1);
    chk("tie_arready", bus.arready, 1'b0);
    @(negedge i_clk); bus.awvalid = 1'b0;
    w_phase(tw);
    b_phase(tw);
    ar_handshake(tr);
    r_phase(tr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end

  txn_t tbl [11];

  initial begin
    bit   ok;
    txn_t ta, tb;

    tbl[0]  = mk(1, 32'h10,   3, 2, INCR,  5,  4,  4,  5,  6,  7, 2'b00, 32'h1,   4'hF);
    tbl[1]  = mk(0, 32'h10,   3, 2, INCR,  6,  0,  4,  5,  6,  7, 2'b00, 32'h0,   4'hF);
    tbl[2]  = mk(0, 32'h18,   3, 2, WRAP,  7,  0,  6,  7,  4,  5, 2'b00, 32'h0,   4'hF);
    tbl[3]  = mk(1, 32'h40,   2, 2, FIXED, 1,  3, 16, 16, 16,  0, 2'b00, 32'h100, 4'h3);
    tbl[4]  = mk(0, 32'h40,   0, 2, FIXED, 2,  0, 16,  0,  0,  0, 2'b00, 32'h0,   4'hF);
    tbl[5]  = mk(1, 32'h2C,   1, 2, WRAP,  3,  2, 11, 10,  0,  0, 2'b00, 32'hA0,  4'hF);
    tbl[6]  = mk(1, 32'h80,   3, 2, INCR,  4,  2, 32, 33,  0,  0, 2'b10, 32'h55,  4'hF);
    tbl[7]  = mk(0, 32'h80,   1, 2, INCR,  8,  0, 32, 33,  0,  0, 2'b00, 32'h0,   4'hF);
    tbl[8]  = mk(1, 32'h2,    3, 1, INCR,  9,  4,  0,  1,  1,  2, 2'b00, 32'hC0,  4'hC);
    tbl[9]  = mk(0, 32'h1000, 0, 2, INCR, 10,  0,  0,  0,  0,  0, 2'b00, 32'h0,   4'hF);
    tbl[10] = mk(0, 32'h28,   1, 2, WRAP, 11,  0, 10, 11,  0,  0, 2'b00, 32'h0,   4'hF);

    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b1;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    i_rst_n = 1'b0;

    // reset state, with awvalid already pending
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_awready", bus.awready, 1'b0);
    chk("rst_wready",  bus.wready,  1'b0);
    chk("rst_bvalid",  bus.bvalid,  1'b0);
    chk("rst_rvalid",  bus.rvalid,  1'b0);
    chk("rst_rlast",   bus.rlast,   1'b0);
    chk("rst_rdata",   bus.rdata,   32'h0);
    chk("rst_bresp",   bus.bresp,   2'b00);
    chk("rst_bid",     bus.bid,     4'h0);
    chk("rst_mem_en",  o_mem_en,    1'b0);
    chk("rst_mem_addr", o_mem_addr, 10'h0);
    bus.awvalid = 1'b0;
    @(negedge i_clk); i_rst_n = 1'b1;

    // simultaneous requests, twice: write first each time
    ta = mk(1, 32'h200, 0, 2, INCR, 2, 1, 128, 0, 0, 0, 2'b00, 32'hDEAD0001, 4'hF);
    tb = mk(0, 32'h200, 0, 2, INCR, 3, 0, 128, 0, 0, 0, 2'b00, 32'h0, 4'hF);
    tie_round(ta, tb);
    ta = mk(1, 32'h204, 0, 2, INCR, 12, 1, 129, 0, 0, 0, 2'b00, 32'hBEEF0002, 4'hF);
    tb = mk(0, 32'h204, 0, 2, INCR, 13, 0, 129, 0, 0, 0, 2'b00, 32'h0, 4'hF);
    tie_round(ta, tb);

    for (int i = 0; i < 11; i++) begin
      @(negedge i_clk);
      if (tbl[i].wr) begin
        set_aw(tbl[i]); aw_handshake(); w_phase(tbl[i]); b_phase(tbl[i]);
      end else begin
        set_ar(tbl[i]); ar_handshake(tbl[i]); r_phase(tbl[i]);
      end
    end

    // reset while a read beat is waiting on rready
    ta = mk(0, 32'h10, 1, 2, INCR, 14, 0, 4, 5, 0, 0, 2'b00, 32'h0, 4'hF);
    @(negedge i_clk);
    set_ar(ta); ar_handshake(ta);
    bus.rready = 1'b0;
    wait_hi(4, "rvalid_before_reset", ok);
    #2; i_rst_n = 1'b0; #1;
    chk("rst_mid_rvalid", bus.rvalid, 1'b0);
    chk("rst_mid_rdata",  bus.rdata,  32'h0);
    chk("rst_mid_mem_en", o_mem_en,   1'b0);
    rd_q.delete();
    bus.arvalid = 1'b1; #1;
    chk("rst_mid_arready", bus.arready, 1'b0);
    bus.arvalid = 1'b0;
    repeat (2) begin
      @(negedge i_clk); #1;
      chk("rst_mid_no_strobe", o_mem_en, 1'b0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tb = mk(0, 32'h14, 0, 2, INCR, 15, 0, 5, 0, 0, 0, 2'b00, 32'h0, 4'hF);
    set_ar(tb);
    #1;
    chk("post_reset_arready", bus.arready, 1'b1);
    @(negedge i_clk);
    bus.arvalid = 1'b0;
    rd_q.push_back({shadow[tb.exp_w[0]], 1'b1, tb.id});
    r_phase(tb);

    chk("aw_ar_never_together", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axi4_sram_ctrl.md
AXI4_SRAM_CTRL -- requirements
Module: axi4_sram_ctrl

Interface
REQ-001 SHALL take parameter ADDR_WIDTH, default 32, meaning AXI byte-address width.
REQ-002 SHALL take parameter DATA_WIDTH, default 32, meaning AXI/SRAM data width, a power of two and at least 8.
REQ-003 SHALL take parameter MEM_DEPTH_LOG2, default 10, meaning SRAM word-address width.
REQ-004 SHALL have port i_clk  input  1  sole clock; all logic samples on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port axi_if  interface  -  std axi4_if slave modport; the block drives awready, wready, bvalid, bresp, bid, buser, arready, rvalid, rlast, rdata, rresp, rid and ruser.
REQ-007 SHALL have port o_mem_en  output  1  SRAM access strobe.
REQ-008 SHALL have port o_mem_we  output  1  SRAM write enable, qualified by o_mem_en.
REQ-009 SHALL have port o_mem_addr  output  MEM_DEPTH_LOG2  SRAM word address.
REQ-010 SHALL have port o_mem_wdata  output  DATA_WIDTH  SRAM write data.
REQ-011 SHALL have port o_mem_wstrb  output  DATA_WIDTH/8  SRAM byte enables.
REQ-012 SHALL have port i_mem_rdata  input  DATA_WIDTH  SRAM read data, valid exactly 1 cycle after a read strobe.

Function
REQ-013 SHALL implement the FSM states IDLE, WDATA, WRESP, RADDR, RDATA, serving one burst at a time.
REQ-014 SHALL, in IDLE, grant the write channel if only awvalid is high, grant the read channel if only arvalid is high, and grant the channel not granted last if both are high.
REQ-015 SHALL assert awready or arready for exactly the single IDLE cycle of the grant, latching addr, id, len, size and burst; IDLE->WDATA on a write grant, IDLE->RADDR on a read grant.
REQ-016 SHALL compute the word address as byte address >> log2(DATA_WIDTH/8), truncated to MEM_DEPTH_LOG2 bits (wrap-around through the address space is silent).
REQ-017 SHALL advance the beat address as follows: FIXED unchanged; INCR plus 1<<size bytes; WRAP plus 1<<size, wrapped inside the aligned block of (len+1)<<size bytes.
REQ-018 SHALL hold wready high in WDATA, and on each wvalid&&wready pulse o_mem_en=o_mem_we=1 with wdata, wstrb and the current address in that same cycle.
REQ-019 SHALL leave WDATA on the wlast handshake for WRESP; bresp SHALL be OKAY if the beat count equals len+1 and SLVERR otherwise.
REQ-020 SHALL, in WRESP, hold bvalid=1 with bid equal to the latched awid until bready, then go to IDLE.
REQ-021 SHALL, in RADDR, pulse o_mem_en=1 with o_mem_we=0 for one cycle, then go to RDATA.
REQ-022 SHALL, in RDATA, register i_mem_rdata and present it with rvalid=1, rid equal to the latched arid, rresp OKAY and rlast=1 only on beat len, held stable until rready.
REQ-023 SHALL return from RDATA to RADDR on a non-last rready handshake and to IDLE on a last one; read-to-read beat throughput is one beat per 2 cycles plus backpressure.
REQ-024 SHALL keep buser and ruser at 0, and keep o_mem_en at 0 in IDLE, WRESP and RDATA.
REQ-025 SHALL never assert awready and arready in the same cycle, and SHALL assert neither outside IDLE.

Reset
REQ-026 SHALL, while i_rst_n=0, force state IDLE, last-grant=read (so write wins the first tie), and all ready, valid, last, resp, id, data and mem outputs to 0.
REQ-027 SHALL, on reset asserted mid-burst, abandon the burst immediately with no further SRAM strobes and no response issued.

Verification
REQ-028 SHALL pass: INCR write awaddr=0x10, len=3, size=2 with wdata 1..4 -> SRAM writes at words 4,5,6,7 on consecutive cycles; bresp OKAY; bid=awid.
REQ-029 SHALL pass: INCR read of the same region with rready held high -> rdata 1..4, rlast on beat 4 only, rid=arid, 2 cycles per beat.
REQ-030 SHALL pass: awvalid and arvalid rising in the same cycle, twice -> write granted first, read second; awready and arready never high together.
REQ-031 SHALL pass: WRAP read at 0x18, len=3, size=2 -> words 6,7,4,5.
REQ-032 SHALL pass: write with len=3 but wlast on beat 2 -> 2 SRAM writes; bresp SLVERR.
REQ-033 SHALL pass: reset asserted during RDATA with rready=0 -> rvalid drops asynchronously; after release, IDLE accepts a new arvalid within 1 cycle.
